// File: rtl/z80_sound_comm_pkg.sv
// rtl/z80_sound_comm_pkg.sv - shared constants and port decode for the Z80 sound command channel (CMD_FIFO_EN option)
package z80_sound_comm_pkg;

  // Z80 I/O port map (A[4:0])
  localparam logic [4:0] PORT_CMD     = 5'h00;
  localparam logic [4:0] PORT_NMI_EN  = 5'h08;
  localparam logic [4:0] PORT_REPLY   = 5'h0C;
  localparam logic [4:0] PORT_NMI_DIS = 5'h18;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FIFO_AW     = 2;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_REPLY,
    WR_NMI_EN,
    WR_NMI_DIS
  } wr_op_e;

  // Maps a Z80 write address onto the action it triggers; unknown ports do nothing.
  function automatic wr_op_e decode_wr(input logic [4:0] addr);
    case (addr)
      PORT_REPLY:   return WR_REPLY;
      PORT_NMI_EN:  return WR_NMI_EN;
      PORT_NMI_DIS: return WR_NMI_DIS;
      default:      return WR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/z80_sound_comm_strobe_sync.sv
// rtl/z80_sound_comm_strobe_sync.sv - active-low strobe synchroniser with edge pulses
module strobe_sync
  import z80_sound_comm_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe_n,
  output logic o_fall,
  output logic o_rise
);

  // Chain and history copy reset to the idle (high) level so reset release never looks like an edge.
  logic [STAGES-1:0] r_chain;
  logic              r_last;

  // Shift the async strobe through the flop chain and keep one extra copy of the last stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '1;
      r_last  <= 1'b1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_strobe_n};
      r_last  <= r_chain[STAGES-1];
    end
  end

  // Pulses are a pure AND of two flops, so they are glitch-free and one clock wide.
  assign o_fall = r_last & ~r_chain[STAGES-1];
  assign o_rise = ~r_last & r_chain[STAGES-1];

endmodule

// File: rtl/z80_sound_comm.sv
// rtl/z80_sound_comm.sv - Z80-side sound command latch/FIFO, reply latch and NMI (CMD_FIFO_EN selects FIFO)
module z80_sound_comm
  import z80_sound_comm_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_AW     = DEF_FIFO_AW
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic [7:0] M68K_CMD,
  input  logic       nCMD_WR,
  output logic [7:0] REPLY,
  input  logic [4:0] Z80_ADDR,
  input  logic       nIORQ,
  input  logic       nRD,
  input  logic       nWR,
  input  logic [7:0] Z80_DIN,
  output logic [7:0] Z80_DOUT,
  output logic       Z80_DOE,
  output logic       nNMI,
  output logic       CMD_PEND,
  output logic       CMD_OVF
);

  logic w_cmd_fall, w_cmd_rise;
  logic w_rd_fall, w_rd_rise;
  logic w_wr_fall, w_wr_rise;
  logic w_rd_n, w_wr_n;
  logic w_pop_req;
  logic w_pend;
  logic [7:0] w_cmd_q;
  logic w_doe;
  logic w_unused_edges;

  logic [4:0] r_rd_addr;
  logic [7:0] r_reply;
  logic       r_nmi_en;
  logic       r_nmi_n;

  assign w_rd_n = nIORQ | nRD;
  assign w_wr_n = nIORQ | nWR;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_cmd (
    .i_clk      (CLK_24M),
    .i_rst      (RESET),
    .i_strobe_n (nCMD_WR),
    .o_fall     (w_cmd_fall),
    .o_rise     (w_cmd_rise)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .i_clk      (CLK_24M),
    .i_rst      (RESET),
    .i_strobe_n (w_rd_n),
    .o_fall     (w_rd_fall),
    .o_rise     (w_rd_rise)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .i_clk      (CLK_24M),
    .i_rst      (RESET),
    .i_strobe_n (w_wr_n),
    .o_fall     (w_wr_fall),
    .o_rise     (w_wr_rise)
  );

  // Only the falling edges of the 68K and Z80 write strobes matter.
  assign w_unused_edges = w_cmd_rise | w_wr_rise;

  // Capture the read address at the start of the access so completion decodes a stable value.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      r_rd_addr <= '0;
    end else if (w_rd_fall) begin
      r_rd_addr <= Z80_ADDR;
    end
  end

  assign w_pop_req = w_rd_rise & (r_rd_addr == PORT_CMD);

  // Z80 port writes: reply byte and NMI enable/disable.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      r_reply  <= 8'h00;
      r_nmi_en <= 1'b0;
    end else if (w_wr_fall) begin
      case (decode_wr(Z80_ADDR))
        WR_REPLY:   r_reply  <= Z80_DIN;
        WR_NMI_EN:  r_nmi_en <= 1'b1;
        WR_NMI_DIS: r_nmi_en <= 1'b0;
        default:    ;
      endcase
    end
  end

`ifdef CMD_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]       r_fifo [DEPTH];
  logic [FIFO_AW:0] r_wp, r_rp;
  logic             r_ovf;
  logic             w_empty, w_full, w_pop, w_push, w_drop;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) &&
                   (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
  assign w_pop   = w_pop_req & ~w_empty;
  // A pop in the same clock frees a slot, so a push into a full FIFO still lands.
  assign w_push  = w_cmd_fall & (~w_full | w_pop);
  assign w_drop  = w_cmd_fall & w_full & ~w_pop;

  // Command FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= 8'h00;
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp[FIFO_AW-1:0]] <= M68K_CMD;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_pend  = ~w_empty;
  assign w_cmd_q = w_empty ? 8'h00 : r_fifo[r_rp[FIFO_AW-1:0]];
  assign CMD_OVF = r_ovf;
`else
  localparam int unused_fifo_depth = 1 << FIFO_AW;

  logic [7:0] r_cmd;
  logic       r_pend;

  // Single command latch; a new capture wins over a same-clock read completion.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      r_cmd  <= 8'h00;
      r_pend <= 1'b0;
    end else begin
      if (w_cmd_fall) begin
        r_cmd  <= M68K_CMD;
        r_pend <= 1'b1;
      end else if (w_pop_req) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign w_pend  = r_pend;
  assign w_cmd_q = r_cmd;
  assign CMD_OVF = 1'b0;
`endif

  // NMI request is registered so it is glitch-free toward the Z80.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      r_nmi_n <= 1'b1;
    end else begin
      r_nmi_n <= ~(r_nmi_en & w_pend);
    end
  end

  // Read enable is combinational from the pins so data is on the bus with no latency.
  assign w_doe    = ~RESET & ~nIORQ & ~nRD & (Z80_ADDR == PORT_CMD);
  assign Z80_DOE  = w_doe;
  assign Z80_DOUT = w_doe ? w_cmd_q : 8'h00;
  assign REPLY    = r_reply;
  assign nNMI     = r_nmi_n;
  assign CMD_PEND = w_pend;

endmodule

// File: tb/tb_z80_sound_comm.sv
// tb/tb_z80_sound_comm.sv - directed scoreboard bench for z80_sound_comm (CMD_FIFO_EN section when defined)
module tb_z80_sound_comm;

  localparam int SS = 2;

  logic       CLK_24M;
  logic       RESET;
  logic [7:0] M68K_CMD;
  logic       nCMD_WR;
  logic [7:0] REPLY;
  logic [4:0] Z80_ADDR;
  logic       nIORQ;
  logic       nRD;
  logic       nWR;
  logic [7:0] Z80_DIN;
  logic [7:0] Z80_DOUT;
  logic       Z80_DOE;
  logic       nNMI;
  logic       CMD_PEND;
  logic       CMD_OVF;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;

  z80_sound_comm #(.SYNC_STAGES(SS), .FIFO_AW(2)) dut (
    .CLK_24M  (CLK_24M),
    .RESET    (RESET),
    .M68K_CMD (M68K_CMD),
    .nCMD_WR  (nCMD_WR),
    .REPLY    (REPLY),
    .Z80_ADDR (Z80_ADDR),
    .nIORQ    (nIORQ),
    .nRD      (nRD),
    .nWR      (nWR),
    .Z80_DIN  (Z80_DIN),
    .Z80_DOUT (Z80_DOUT),
    .Z80_DOE  (Z80_DOE),
    .nNMI     (nNMI),
    .CMD_PEND (CMD_PEND),
    .CMD_OVF  (CMD_OVF)
  );

  initial CLK_24M = 1'b0;
  always #20 CLK_24M = ~CLK_24M;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_24M);
  endtask

  // Scoreboard side of a 68K write: a latch keeps only the newest byte, a FIFO keeps four.
  task automatic model_push(input logic [7:0] b);
`ifdef CMD_FIFO_EN
    if (exp_q.size() < 4) exp_q.push_back(b);
    else exp_ovf = 1'b1;
`else
    exp_q.delete();
    exp_q.push_back(b);
`endif
  endtask

  task automatic m68k_write(input logic [7:0] b);
    model_push(b);
    M68K_CMD = b;
    nCMD_WR  = 1'b0;
    cyc(6);
    nCMD_WR  = 1'b1;
    cyc(6);
  endtask

  task automatic z80_write(input logic [4:0] a, input logic [7:0] d);
    Z80_ADDR = a;
    Z80_DIN  = d;
    nIORQ    = 1'b0;
    nWR      = 1'b0;
    cyc(6);
    nWR      = 1'b1;
    nIORQ    = 1'b1;
    cyc(6);
  endtask

  task automatic z80_read_cmd(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    Z80_ADDR = 5'h00;
    nIORQ    = 1'b0;
    nRD      = 1'b0;
    #1;
    chk({tag, "_doe"}, {7'd0, Z80_DOE}, 8'h01);
    chk({tag, "_dout"}, Z80_DOUT, e);
    cyc(6);
    nRD      = 1'b1;
    nIORQ    = 1'b1;
    cyc(6);
  endtask

  initial begin : main
    bit ok;
    exp_ovf  = 1'b0;
    RESET    = 1'b1;
    M68K_CMD = 8'h00;
    nCMD_WR  = 1'b1;
    Z80_ADDR = 5'h00;
    nIORQ    = 1'b1;
    nRD      = 1'b1;
    nWR      = 1'b1;
    Z80_DIN  = 8'h00;
    cyc(3);
    RESET = 1'b0;
    cyc(4);

    chk("rst_reply", REPLY, 8'h00);
    chk("rst_nnmi", {7'd0, nNMI}, 8'h01);
    chk("rst_pend", {7'd0, CMD_PEND}, 8'h00);
    chk("rst_doe", {7'd0, Z80_DOE}, 8'h00);
    chk("rst_dout", Z80_DOUT, 8'h00);
    chk("rst_ovf", {7'd0, CMD_OVF}, 8'h00);

    // NMI masked: command pends but no NMI until enabled
    m68k_write(8'h11);
    chk("mask_pend", {7'd0, CMD_PEND}, 8'h01);
    chk("mask_nnmi_off", {7'd0, nNMI}, 8'h01);
    z80_write(5'h08, 8'h00);
    chk("mask_nnmi_en", {7'd0, nNMI}, 8'h00);
    z80_write(5'h18, 8'h00);
    chk("mask_nnmi_dis", {7'd0, nNMI}, 8'h01);
    z80_read_cmd("mask_rd");
    chk("mask_pend_clr", {7'd0, CMD_PEND}, 8'h00);

    // Command with NMI enabled, bounded latency
    z80_write(5'h08, 8'h00);
    model_push(8'h5A);
    M68K_CMD = 8'h5A;
    nCMD_WR  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < SS + 3; i++) begin
      cyc(1);
      if (nNMI === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("nmi_latency", {7'd0, ok}, 8'h01);
    chk("cmd_pend", {7'd0, CMD_PEND}, 8'h01);
    cyc(3);
    nCMD_WR = 1'b1;
    cyc(6);
    z80_read_cmd("cmd_rd");
    chk("cmd_pend_clr", {7'd0, CMD_PEND}, 8'h00);
    chk("cmd_nnmi_clr", {7'd0, nNMI}, 8'h01);

    // Reply latch and ignored port
    z80_write(5'h0C, 8'hA5);
    chk("reply_wr", REPLY, 8'hA5);
    z80_write(5'h04, 8'h3C);
    chk("reply_hold", REPLY, 8'hA5);

    // Read of another port does not drive the bus
    m68k_write(8'h66);
    Z80_ADDR = 5'h04;
    nIORQ = 1'b0;
    nRD   = 1'b0;
    #1;
    chk("other_doe", {7'd0, Z80_DOE}, 8'h00);
    chk("other_dout", Z80_DOUT, 8'h00);
    cyc(6);
    nRD = 1'b1;
    nIORQ = 1'b1;
    cyc(6);
    chk("other_pend_kept", {7'd0, CMD_PEND}, 8'h01);
    z80_read_cmd("other_rd");

    // Back-to-back 68K writes
    m68k_write(8'h77);
    m68k_write(8'h88);
    chk("b2b_ovf", {7'd0, CMD_OVF}, {7'd0, exp_ovf});
    while (exp_q.size() > 0) z80_read_cmd("b2b_rd");
    chk("b2b_pend_clr", {7'd0, CMD_PEND}, 8'h00);

    // Collision: capture and read completion resolve in the same clock
    m68k_write(8'h22);
    Z80_ADDR = 5'h00;
    nIORQ = 1'b0;
    nRD   = 1'b0;
    #1;
    chk("col_dout_old", Z80_DOUT, exp_q.pop_front());
    cyc(6);
    model_push(8'h33);
    M68K_CMD = 8'h33;
    nCMD_WR  = 1'b0;
    nRD      = 1'b1;
    nIORQ    = 1'b1;
    cyc(6);
    nCMD_WR  = 1'b1;
    cyc(4);
    chk("col_pend", {7'd0, CMD_PEND}, 8'h01);
    z80_read_cmd("col_rd");

    // Reset in the middle of a Z80 write
    m68k_write(8'h44);
    chk("pre_rst_nnmi", {7'd0, nNMI}, 8'h00);
    Z80_ADDR = 5'h0C;
    Z80_DIN  = 8'hFF;
    nIORQ    = 1'b0;
    nWR      = 1'b0;
    cyc(1);
    #3 RESET = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    chk("mid_rst_reply", REPLY, 8'h00);
    chk("mid_rst_nnmi", {7'd0, nNMI}, 8'h01);
    chk("mid_rst_pend", {7'd0, CMD_PEND}, 8'h00);
    chk("mid_rst_doe", {7'd0, Z80_DOE}, 8'h00);
    nIORQ = 1'b1;
    nWR   = 1'b1;
    cyc(2);
    RESET = 1'b0;
    cyc(8);
    chk("post_rst_pend", {7'd0, CMD_PEND}, 8'h00);
    chk("post_rst_reply", REPLY, 8'h00);
    m68k_write(8'h99);
    chk("post_rst_nmi_masked", {7'd0, nNMI}, 8'h01);
    z80_read_cmd("post_rst_rd");

`ifdef CMD_FIFO_EN
    for (int b = 1; b <= 5; b++) m68k_write(8'(b));
    chk("fifo_ovf", {7'd0, CMD_OVF}, {7'd0, exp_ovf});
    for (int k = 0; k < 4; k++) z80_read_cmd("fifo_rd");
    chk("fifo_pend_clr", {7'd0, CMD_PEND}, 8'h00);
    chk("fifo_ovf_sticky", {7'd0, CMD_OVF}, 8'h01);
    chk("fifo_empty_q", 8'(exp_q.size()), 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/z80_sound_comm.md
Name: z80_sound_comm

Overview:
- Z80-side end of the 68K-to-Z80 sound command channel.
- Captures the command byte written by the 68K, presents it on Z80 I/O port 0x00, and raises Z80 NMI when a command is pending and NMI is enabled.
- Accepts a Z80 reply byte on port 0x0C for the 68K to read back.
- Sits between the C1 sound-code decode and the Z80 I/O bus; all strobes are resynchronised to CLK_24M.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each strobe synchroniser (legal values 2..3).
- FIFO_AW, 2, command FIFO address width (depth 2**FIFO_AW); used only with CMD_FIFO_EN.

Ports:
- CLK_24M  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- M68K_CMD  in  8  command byte from the 68K data bus; stable while nCMD_WR is low.
- nCMD_WR  in  1  async active-low 68K sound-code write strobe.
- REPLY  out  8  reply latch, read back by the 68K.
- Z80_ADDR  in  5  Z80 A[4:0] for port decode.
- nIORQ  in  1  async active-low Z80 I/O request.
- nRD  in  1  async active-low Z80 read strobe.
- nWR  in  1  async active-low Z80 write strobe.
- Z80_DIN  in  8  Z80 write data.
- Z80_DOUT  out  8  Z80 read data.
- Z80_DOE  out  1  Z80 read-data output enable.
- nNMI  out  1  active-low Z80 NMI.
- CMD_PEND  out  1  a command is waiting for the Z80.
- CMD_OVF  out  1  sticky: a command was dropped (always 0 without CMD_FIFO_EN).

Behaviour:
- Clock and reset:
  - One clock, CLK_24M. RESET is asynchronous and active-high.
  - Reset values: cmd latch 0x00, REPLY 0x00, nmi_en 0, CMD_PEND 0, CMD_OVF 0, nNMI 1, Z80_DOE 0.
- Synchronisers:
  - nCMD_WR, (nIORQ|nRD) and (nIORQ|nWR) each pass through a SYNC_STAGES flop chain.
  - Edge detection uses the last stage versus one extra registered copy.
  - Strobes must stay low for at least SYNC_STAGES+2 clocks; shorter strobes may be missed.
- Command capture:
  - On the synchronised falling edge of nCMD_WR, sample M68K_CMD into the cmd latch and set CMD_PEND.
  - Capture happens SYNC_STAGES+1 clocks after the async fall.
- Z80 read path:
  - Z80_DOE = ~nIORQ & ~nRD & (Z80_ADDR==5'h00). This is combinational from the async pins, so there is no data latency.
  - Z80_DOUT = cmd latch (FIFO head under CMD_FIFO_EN) when Z80_DOE is high, else 0x00.
  - On the synchronised rising edge of a port-0x00 read, clear CMD_PEND.
  - The address is registered at the falling edge of the same strobe so the decode is stable.
- Z80 write path:
  - Act on the synchronised falling edge of (nIORQ|nWR), using Z80_ADDR and Z80_DIN sampled that cycle.
  - Port 0x0C: REPLY <= Z80_DIN.
  - Port 0x08: nmi_en <= 1.
  - Port 0x18: nmi_en <= 0.
  - Other ports: ignored.
- NMI:
  - nNMI = ~(nmi_en & CMD_PEND), registered, so it lags its cause by 1 clock.
  - Enabling NMI while a command is pending asserts nNMI on the next clock.
- Simultaneous events:
  - Command capture and port-0 read completion in the same clock: set wins, CMD_PEND stays 1.
  - Back-to-back 68K writes without a Z80 read: newest byte overwrites the latch; CMD_OVF stays 0.
- REPLY holds its value until the next port-0x0C write or RESET.
- Reset mid-access: every state returns to its reset value immediately. The synchroniser chains reset to 1, so no spurious edges appear after reset release.

Optional Feature:
- Macro: CMD_FIFO_EN.
- Defined:
  - The cmd latch becomes a 2**FIFO_AW-entry FIFO.
  - Capture pushes; completion of a port-0x00 read pops.
  - CMD_PEND = ~empty. Z80_DOUT shows the head entry, or 0x00 when empty.
  - Push when full drops the byte and sets CMD_OVF (sticky until RESET).
  - Push and pop in the same clock when full: the pop frees the slot first and the push is accepted.
  - Pop when empty: no effect.
- Undefined: single-latch behaviour as described above.

Decomposition:
- Shared package: port constants PORT_CMD=5'h00, PORT_NMI_EN=5'h08, PORT_REPLY=5'h0C, PORT_NMI_DIS=5'h18; default SYNC_STAGES.
- One sub-module, strobe_sync: parameterised synchroniser with registered rise/fall pulse outputs, instantiated three times.

Test Plan:
- Reset: assert RESET mid-simulation -> REPLY=0x00, nNMI=1, CMD_PEND=0, Z80_DOE=0 immediately.
- Command and NMI:
  - Z80 writes port 0x08, then 68K writes 0x5A -> CMD_PEND=1 and nNMI=0 within SYNC_STAGES+3 clocks.
  - Z80 reads port 0x00 -> Z80_DOUT=0x5A.
  - After nRD rises -> CMD_PEND=0, nNMI=1.
- NMI mask: NMI disabled, 68K writes 0x11 -> CMD_PEND=1, nNMI=1. Z80 writes port 0x08 -> nNMI=0. Z80 writes port 0x18 -> nNMI=1.
- Reply: Z80 writes 0xA5 to port 0x0C -> REPLY=0xA5. Writes to port 0x04 -> REPLY unchanged.
- Collision: 68K write lands in the same clock as port-0 read completion -> CMD_PEND stays 1, latch holds the new byte.
- CMD_FIFO_EN, FIFO_AW=2:
  - Push 0x01..0x05 -> CMD_OVF=1.
  - Four reads return 0x01..0x04, then CMD_PEND=0.
